// File: rtl/uart_loader_pkg.sv
// Shared constants for the UART loader: protocol bytes, UART register map,
// FSM state encodings and UART access opcodes.
package uart_loader_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] RESP_ACK  = 8'h06;
    localparam logic [7:0] RESP_NAK  = 8'h15;

    localparam logic [7:0] UART_REG_ADDR = 8'h00;

    localparam int ST_RX_AVAIL  = 0;
    localparam int ST_TX_ACTIVE = 1;

    // Encoding order matters: ADR2..DATA form the contiguous range where the
    // inter-byte timeout is armed.
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_CMD   = 4'd1;
    localparam logic [3:0] S_ADR2  = 4'd2;
    localparam logic [3:0] S_ADR1  = 4'd3;
    localparam logic [3:0] S_ADR0  = 4'd4;
    localparam logic [3:0] S_LEN1  = 4'd5;
    localparam logic [3:0] S_LEN0  = 4'd6;
    localparam logic [3:0] S_DATA  = 4'd7;
    localparam logic [3:0] S_MEMWR = 4'd8;
    localparam logic [3:0] S_RESP  = 4'd9;

    localparam logic [1:0] OP_POLL  = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

endpackage

// File: rtl/uart_loader_if.sv
// UART register port and memory write port of the loader.
// master = loader side, slave = UART/memory side.
interface uart_loader_if #(
    parameter int ADDR_W = 24
) ();
    logic [7:0]        u_addr;
    logic [15:0]       u_data_write;
    logic [15:0]       u_data_read;
    logic              u_uds;
    logic              u_lds;
    logic              u_rw;
    logic              u_ack;
    logic              u_rx_avail_clear;
    logic [ADDR_W-1:0] m_addr;
    logic [15:0]       m_data_write;
    logic              m_uds;
    logic              m_lds;
    logic              m_rw;
    logic              m_ack;

    modport master (
        output u_addr, u_data_write, u_uds, u_lds, u_rw, u_rx_avail_clear,
        output m_addr, m_data_write, m_uds, m_lds, m_rw,
        input  u_data_read, u_ack, m_ack
    );

    modport slave (
        input  u_addr, u_data_write, u_uds, u_lds, u_rw, u_rx_avail_clear,
        input  m_addr, m_data_write, m_uds, m_lds, m_rw,
        output u_data_read, u_ack, m_ack
    );
endinterface

// File: rtl/uart_port_seq.sv
// One UART poll/read/write access per request; done pulses the cycle after ack.
// Strobe is held until ack, and a new access never starts in the done cycle.
module uart_port_seq
    import uart_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic [7:0]  wdata,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        uds,
    output logic        lds,
    output logic        rw,
    output logic [15:0] data_write,
    output logic        rx_avail_clear,
    input  logic [7:0]  data_read,
    input  logic        ack
);
    logic active;

    always_ff @(posedge clk) begin
        if (reset) begin
            active         <= 1'b0;
            uds            <= 1'b0;
            lds            <= 1'b0;
            rw             <= 1'b1;
            done           <= 1'b0;
            rdata          <= 8'h00;
            data_write     <= 16'h0000;
            rx_avail_clear <= 1'b0;
        end else begin
            done           <= 1'b0;
            rx_avail_clear <= 1'b0;
            if (active) begin
                if (ack) begin
                    active         <= 1'b0;
                    uds            <= 1'b0;
                    lds            <= 1'b0;
                    rdata          <= data_read;
                    done           <= 1'b1;
                    rx_avail_clear <= uds & rw;
                end
            end else if (req && en && !done) begin
                // en only gates the start of an access; one in flight always completes
                active <= 1'b1;
                case (op)
                    OP_READ: begin
                        uds <= 1'b1;
                        rw  <= 1'b1;
                    end
                    OP_WRITE: begin
                        uds        <= 1'b1;
                        rw         <= 1'b0;
                        data_write <= {8'h00, wdata};
                    end
                    default: begin
                        lds <= 1'b1;
                        rw  <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: rtl/uart_loader.sv
// UART-driven memory loader: 'W' + 24-bit addr + 16-bit len + data, then ACK/NAK.
// Each UART access and memory cycle is held until its ack; no fixed latency.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int RX_TIMEOUT = 5_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    uart_loader_if.master    bus,
    output logic             busy,
    output logic             err
);
    logic [3:0]        state;
    logic              phase;      // receive states: 0 poll, 1 read; RESP: 0 poll, 1 write
    logic [ADDR_W-1:0] addr;
    logic [15:0]       cnt;
    logic [15:0]       dat;
    logic              pend;       // even byte buffered in dat[15:8]
    logic [7:0]        resp;
    logic [31:0]       tmo;
    logic              mu, ml;

    logic        req, done;
    logic [1:0]  op;
    logic [7:0]  rdata;
    logic        timed, tmo_hit;
    logic [1:0]  nb;

    always_comb begin
        req = (state != S_MEMWR);
        if (state == S_RESP) op = phase ? OP_WRITE : OP_POLL;
        else                 op = phase ? OP_READ  : OP_POLL;
    end

    assign timed   = (state >= S_ADR2) && (state <= S_DATA);
    assign tmo_hit = (RX_TIMEOUT > 0) && (tmo >= 32'(RX_TIMEOUT));
    assign nb      = (mu && ml) ? 2'd2 : 2'd1;
    assign busy    = (state != S_IDLE);

    assign bus.u_addr       = UART_REG_ADDR;
    assign bus.m_addr       = addr;
    assign bus.m_data_write = dat;
    assign bus.m_uds        = mu;
    assign bus.m_lds        = ml;
    assign bus.m_rw         = 1'b0;

    uart_port_seq u_seq (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .req            (req),
        .op             (op),
        .wdata          (resp),
        .done           (done),
        .rdata          (rdata),
        .uds            (bus.u_uds),
        .lds            (bus.u_lds),
        .rw             (bus.u_rw),
        .data_write     (bus.u_data_write),
        .rx_avail_clear (bus.u_rx_avail_clear),
        .data_read      (bus.u_data_read[7:0]),
        .ack            (bus.u_ack)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            phase <= 1'b0;
            addr  <= '0;
            cnt   <= 16'h0000;
            dat   <= 16'h0000;
            pend  <= 1'b0;
            resp  <= 8'h00;
            tmo   <= 32'h0;
            mu    <= 1'b0;
            ml    <= 1'b0;
            err   <= 1'b0;
        end else begin
            if (timed && tmo != 32'hFFFF_FFFF) tmo <= tmo + 32'h1;
            if (state == S_MEMWR) begin
                if (bus.m_ack && (mu || ml)) begin
                    mu    <= 1'b0;
                    ml    <= 1'b0;
                    pend  <= 1'b0;
                    addr  <= addr + ADDR_W'(nb);
                    cnt   <= cnt - 16'(nb);
                    phase <= 1'b0;
                    if (cnt == 16'(nb)) begin
                        state <= S_RESP;
                        resp  <= RESP_ACK;
                    end else begin
                        state <= S_DATA;
                    end
                end
            end else if (done) begin
                if (state == S_RESP) begin
                    if (phase) begin
                        state <= S_IDLE;
                        phase <= 1'b0;
                    end else if (!rdata[ST_TX_ACTIVE]) begin
                        phase <= 1'b1;
                    end
                end else if (!phase) begin
                    if (rdata[ST_RX_AVAIL]) begin
                        if (state == S_IDLE) state <= S_CMD;
                        else                 phase <= 1'b1;
                    end else if (timed && tmo_hit) begin
                        state <= S_RESP;
                        resp  <= RESP_NAK;
                        err   <= 1'b1;
                    end
                end else begin
                    phase <= 1'b0;
                    tmo   <= 32'h0;
                    case (state)
                        S_CMD: begin
                            addr <= '0;
                            if (rdata == CMD_WRITE) begin
                                state <= S_ADR2;
                            end else begin
                                state <= S_RESP;
                                resp  <= RESP_NAK;
                                err   <= 1'b1;
                            end
                        end
                        S_ADR2, S_ADR1, S_ADR0: begin
                            addr  <= (addr << 8) | ADDR_W'(rdata);
                            state <= state + 4'd1;
                        end
                        S_LEN1: begin
                            cnt[15:8] <= rdata;
                            state     <= S_LEN0;
                        end
                        S_LEN0: begin
                            cnt[7:0] <= rdata;
                            if ({cnt[15:8], rdata} == 16'h0000) begin
                                state <= S_RESP;
                                resp  <= RESP_ACK;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                        S_DATA: begin
                            // current byte address is addr + pend
                            if (addr[0] || pend) begin
                                dat[7:0] <= rdata;
                                ml       <= 1'b1;
                                mu       <= pend;
                                state    <= S_MEMWR;
                            end else begin
                                dat[15:8] <= rdata;
                                if (cnt == 16'h0001) begin
                                    mu    <= 1'b1;
                                    state <= S_MEMWR;
                                end else begin
                                    pend <= 1'b1;
                                end
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench: expected memory writes and TX bytes are queued with the
// stimulus; the negedge monitor compares whenever the DUT strobes a port.
module tb_uart_loader;
    import uart_loader_pkg::*;

    typedef struct {
        logic [23:0] addr;
        logic [15:0] data;
        logic        uds;
        logic        lds;
    } mw_t;

    logic clk = 1'b0;
    logic reset, en;
    logic busy, err;

    uart_loader_if #(.ADDR_W(24)) bus ();

    uart_loader #(.ADDR_W(24), .RX_TIMEOUT(100)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .bus   (bus),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    mw_t        exp_mem[$];
    logic [7:0] exp_tx[$];
    logic [7:0] rx_q[$];

    int errs = 0, checks = 0;
    int proto_bad = 0, reads = 0, clears = 0, cyc = 0;
    int tx_busy = 0, last_rx_cyc = 0, tx_cyc = 0;
    bit mem_stall = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic mon_mem();
        mw_t e;
        logic [63:0] got, want;
        got = {7'h0, bus.m_rw, bus.m_addr, bus.m_uds, bus.m_lds,
               bus.m_uds ? bus.m_data_write[15:8] : 8'h00,
               bus.m_lds ? bus.m_data_write[7:0]  : 8'h00};
        if (exp_mem.size() == 0) begin
            check("mem_unexpected", got, 64'h0);
        end else begin
            e = exp_mem.pop_front();
            want = {7'h0, 1'b0, e.addr, e.uds, e.lds,
                    e.uds ? e.data[15:8] : 8'h00,
                    e.lds ? e.data[7:0]  : 8'h00};
            check("mem_write", got, want);
        end
    endtask

    task automatic mon_tx();
        if (exp_tx.size() == 0) begin
            check("tx_unexpected", {48'h0, bus.u_data_write}, 64'hFFFF);
        end else begin
            check("tx_byte", {48'h0, bus.u_data_write}, {56'h0, exp_tx.pop_front()});
        end
    endtask

    // UART and memory responders plus monitor; ack is raised for one cycle
    always @(negedge clk) begin
        cyc++;
        if (bus.u_uds && bus.u_lds) proto_bad++;
        if (bus.u_rx_avail_clear) clears++;
        if (reset) begin
            bus.u_ack = 1'b0;
            bus.m_ack = 1'b0;
        end else begin
            if (tx_busy > 0) tx_busy--;
            if (bus.u_ack) begin
                bus.u_ack = 1'b0;
            end else if (bus.u_lds) begin
                bus.u_data_read = {14'h0, (tx_busy > 0), (rx_q.size() > 0)};
                bus.u_ack = 1'b1;
            end else if (bus.u_uds && bus.u_rw) begin
                if (rx_q.size() > 0) bus.u_data_read = {8'h00, rx_q.pop_front()};
                else proto_bad++;
                reads++;
                last_rx_cyc = cyc;
                bus.u_ack = 1'b1;
            end else if (bus.u_uds) begin
                if (tx_busy > 0) proto_bad++;
                mon_tx();
                tx_cyc  = cyc;
                tx_busy = 3;
                bus.u_ack = 1'b1;
            end
            if (bus.m_ack) begin
                bus.m_ack = 1'b0;
            end else if ((bus.m_uds || bus.m_lds) && !mem_stall) begin
                mon_mem();
                bus.m_ack = 1'b1;
            end
        end
    end

    task automatic send(input logic [7:0] b[]);
        foreach (b[i]) rx_q.push_back(b[i]);
    endtask

    task automatic push_mem(input logic [23:0] a, input logic [15:0] d, input logic u, input logic l);
        mw_t e;
        e.addr = a; e.data = d; e.uds = u; e.lds = l;
        exp_mem.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget && !(rx_q.size() == 0 && exp_tx.size() == 0 &&
                               exp_mem.size() == 0 && !busy)) begin
            @(negedge clk);
            n++;
        end
        check(name, {63'h0, (n < budget)}, 64'h1);
    endtask

    initial begin
        int n, strobes;
        reset = 1'b1;
        en    = 1'b1;
        bus.u_data_read = 16'h0;
        bus.u_ack = 1'b0;
        bus.m_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_strobes", {59'h0, bus.u_uds, bus.u_lds, bus.m_uds, bus.m_lds,
                                bus.u_rx_avail_clear}, 64'h0);
        check("reset_busy_err", {62'h0, busy, err}, 64'h0);
        check("reset_m_addr", {40'h0, bus.m_addr}, 64'h0);
        check("reset_data", {32'h0, bus.m_data_write, bus.u_data_write}, 64'h0);
        check("reset_u_addr", {56'h0, bus.u_addr}, 64'h0);
        reset = 1'b0;

        // aligned 4-byte write
        push_mem(24'h001000, 16'h1122, 1, 1);
        push_mem(24'h001002, 16'h3344, 1, 1);
        exp_tx.push_back(RESP_ACK);
        send('{8'h57, 8'h00, 8'h10, 8'h00, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44});
        wait_idle("done_aligned", 3000);
        check("err_aligned", {63'h0, err}, 64'h0);

        // odd start address
        push_mem(24'h002001, 16'h00AA, 0, 1);
        push_mem(24'h002002, 16'hBBCC, 1, 1);
        exp_tx.push_back(RESP_ACK);
        send('{8'h57, 8'h00, 8'h20, 8'h01, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC});
        wait_idle("done_odd", 3000);

        // address wrap and lone trailing even byte
        push_mem(24'hFFFFFF, 16'h0001, 0, 1);
        push_mem(24'h000000, 16'h0200, 1, 0);
        exp_tx.push_back(RESP_ACK);
        send('{8'h57, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h01, 8'h02});
        wait_idle("done_wrap", 3000);

        // zero length
        exp_tx.push_back(RESP_ACK);
        send('{8'h57, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        wait_idle("done_zero_len", 3000);
        check("err_zero_len", {63'h0, err}, 64'h0);

        // en low in IDLE holds off the loader; then a bad command gives NAK
        en = 1'b0;
        repeat (6) @(negedge clk);
        exp_tx.push_back(RESP_NAK);
        send('{8'h41});
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.u_uds || bus.u_lds) strobes++;
        end
        check("en_low_strobes", 64'(strobes), 64'h0);
        en = 1'b1;
        wait_idle("done_nak", 3000);
        check("nak_err_busy", {62'h0, err, busy}, 64'h2);

        // inter-byte timeout
        exp_tx.push_back(RESP_NAK);
        send('{8'h57, 8'h00});
        wait_idle("done_timeout", 1000);
        n = tx_cyc - last_rx_cyc;
        check("timeout_window", {63'h0, (n >= 100 && n <= 125)}, 64'h1);
        check("timeout_err", {63'h0, err}, 64'h1);

        // reset while a memory cycle is held
        mem_stall = 1'b1;
        send('{8'h57, 8'h00, 8'h30, 8'h00, 8'h00, 8'h02, 8'h55, 8'h66});
        n = 0;
        while (n < 2000 && !(bus.m_uds && bus.m_lds)) begin
            @(negedge clk);
            n++;
        end
        check("memwr_held", {63'h0, (n < 2000)}, 64'h1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_strobes", {60'h0, bus.m_uds, bus.m_lds, bus.u_uds, bus.u_lds}, 64'h0);
        check("rst_mid_busy_err", {62'h0, busy, err}, 64'h0);
        mem_stall = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        push_mem(24'h004000, 16'hDEAD, 1, 1);
        exp_tx.push_back(RESP_ACK);
        send('{8'h57, 8'h00, 8'h40, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD});
        wait_idle("done_after_reset", 3000);
        check("err_after_reset", {63'h0, err}, 64'h0);

        repeat (5) @(negedge clk);
        check("protocol", 64'(proto_bad), 64'h0);
        check("rx_clear_pulses", 64'(clears), 64'(reads));
        check("queues_empty", 64'(exp_mem.size() + exp_tx.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
